ftoi_result_stage: RTL



---
 rtl/fpu_pkg.sv | 15 +
 rtl/fpu_sync_fifo.sv | 68 ++++++
 rtl/ftoi_result_stage.sv | 116 +++++++++++
 3 files changed

// File: rtl/fpu_pkg.sv
// Shared FPU constants: 32-bit signed integer limits used when a
// float-to-int conversion overflows, and the destination tag width.
package fpu_pkg;

    localparam logic [31:0] INT32_MAX = 32'h7FFF_FFFF;
    localparam logic [31:0] INT32_MIN = 32'h8000_0000;
    localparam int          FPU_TAG_W = 5;

    // Saturated integer for an overflowed conversion: positive sources clamp
    // to INT32_MAX, negative sources to INT32_MIN.
    function automatic logic [31:0] ftoi_sat_value(input logic sign);
        return sign ? INT32_MIN : INT32_MAX;
    endfunction

endpackage

// File: rtl/fpu_sync_fifo.sv
// Generic registered synchronous FIFO. DEPTH must be a power of two (>= 2)
// so pointers wrap naturally. The read side shows the head entry from
// registered storage only: a word written in cycle N appears at rd_data in
// cycle N+1 at the earliest. rd_data reads as zero while empty.
module fpu_sync_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic [WIDTH-1:0]         wr_data,
    input  logic                     pop,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int            AW       = $clog2(DEPTH);
    localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Requests are qualified locally so a careless caller cannot overrun
    // or underrun the storage.
    assign push_ok = push && !full;
    assign pop_ok  = pop && !empty;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);

    // Head entry, forced to zero while the FIFO holds nothing.
    assign rd_data = empty ? '0 : mem[rd_ptr];

    // Storage array: data words need no reset, validity lives in count.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/ftoi_result_stage.sv
// Registered result stage behind the combinational float-to-int converter.
// Buffers {data, tag, ovf} in a small FIFO, clamps overflowed results to
// INT32_MAX/INT32_MIN, and keeps a sticky overflow flag plus a saturating
// overflow event counter for the FPU status logic.
//
// Build option: define FTOI_SAT_EN to enable the clamp. Without it the raw
// converter result is stored unchanged; the overflow bit, flag and counter
// behave identically either way.
module ftoi_result_stage
    import fpu_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int TAG_W = FPU_TAG_W,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_y,
    input  logic             in_ovf,
    input  logic             in_sign,
    input  logic [TAG_W-1:0] in_tag,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [TAG_W-1:0] out_tag,
    output logic             out_ovf,
    input  logic             clr_flags,
    output logic             ovf_flag,
    output logic [CNT_W-1:0] ovf_count
);

`ifdef FTOI_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    localparam int                    ENTRY_W  = 32 + TAG_W + 1;
    localparam int                    AW       = $clog2(DEPTH);
    localparam logic [AW:0]           FULL_CNT = (AW+1)'(DEPTH);

    logic [ENTRY_W-1:0] wr_entry;
    logic [ENTRY_W-1:0] rd_entry;
    logic [31:0]        entry_data;
    logic [AW:0]        fifo_count;
    logic               fifo_full;
    logic               fifo_empty;
    logic               push;
    logic               pop;

    // Handshake rules for both sides: a transfer happens on a rising clk
    // edge when valid and ready are both high. The producer holds its
    // payload stable until accepted; in_ready depends only on registered
    // occupancy (and reset), never on out_ready, so a pop frees a slot for
    // the producer one cycle later.
    assign in_ready  = !rst && !fifo_full;
    assign out_valid = !fifo_empty;
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    // Result word stored at push time: clamped on overflow when enabled.
    always_comb begin
        entry_data = in_y;
        if (SAT_EN && in_ovf) begin
            entry_data = ftoi_sat_value(in_sign);
        end
    end

    assign wr_entry = {entry_data, in_tag, in_ovf};

    fpu_sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (ENTRY_W)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (push),
        .wr_data (wr_entry),
        .pop     (pop),
        .rd_data (rd_entry),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    // The FIFO zeroes its read word while empty, so the outputs read 0 then.
    assign {out_data, out_tag, out_ovf} = rd_entry;

    // Sticky flag and saturating counter; an overflow push beats a
    // coincident clear, restarting the count at one.
    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_flag  <= 1'b0;
            ovf_count <= '0;
        end else if (push && in_ovf) begin
            ovf_flag <= 1'b1;
            if (clr_flags) begin
                ovf_count <= CNT_W'(1);
            end else if (!(&ovf_count)) begin
                ovf_count <= ovf_count + CNT_W'(1);
            end
        end else if (clr_flags) begin
            ovf_flag  <= 1'b0;
            ovf_count <= '0;
        end
    end

    // Occupancy never exceeds DEPTH and the full indication agrees with it.
    occupancy_bound: assert property (
        @(posedge clk) disable iff (rst)
        (fifo_count <= FULL_CNT) && (fifo_full == (fifo_count == FULL_CNT))
    );

endmodule
